// File: rtl/lif_tick_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire controller: one shared update datapath
// walks N_NEURONS virtual neurons per tick and emits spike IDs over valid/ready.
module lif_tick_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int ID_W      = 3,
    parameter int REFRAC    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_start,
    input  logic [N_NEURONS-1:0] syn,
    input  logic [7:0]           weight,
    input  logic [7:0]           threshold,
    input  logic [7:0]           leak,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    input  logic                 spike_ready,
    output logic [ID_W-1:0]      spike_id,
    input  logic [ID_W-1:0]      rd_idx,
    output logic [7:0]           rd_v
);

    localparam logic [1:0]      S_IDLE      = 2'd0;
    localparam logic [1:0]      S_UPDATE    = 2'd1;
    localparam logic [1:0]      S_DONE      = 2'd2;
    localparam logic [ID_W-1:0] LAST_IDX    = ID_W'(N_NEURONS - 1);
    localparam logic [3:0]      REFRAC_INIT = 4'(REFRAC);

    logic [1:0]           state;
    logic [ID_W-1:0]      idx;
    logic [N_NEURONS-1:0] syn_q;
    logic [7:0]           v_mem      [N_NEURONS];
    logic [3:0]           refrac_mem [N_NEURONS];

    logic [7:0] v_cur;
    logic [7:0] w_eff;
    logic [8:0] sum_raw;
    logic [7:0] sum_sat;
    logic [7:0] v_leaked;
    logic       in_refrac;
    logic       fire;
    logic       slot_free;
    logic       commit;

    // A firing neuron may only commit when the spike slot can take its event;
    // otherwise the whole update is re-evaluated next cycle with idx held.
    always_comb begin
        v_cur     = v_mem[idx];
        in_refrac = (refrac_mem[idx] != 4'd0);
        w_eff     = syn_q[idx] ? weight : 8'd0;
        sum_raw   = {1'b0, v_cur} + {1'b0, w_eff};
        sum_sat   = sum_raw[8] ? 8'hFF : sum_raw[7:0];
        v_leaked  = (sum_sat > leak) ? (sum_sat - leak) : 8'd0;
        fire      = (state == S_UPDATE) && !in_refrac && (sum_sat >= threshold);
        slot_free = !spike_valid || spike_ready;
        commit    = (state == S_UPDATE) && (!fire || slot_free);
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            syn_q       <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            rd_v        <= 8'd0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]      <= 8'd0;
                refrac_mem[i] <= 4'd0;
            end
        end else begin
            rd_v <= v_mem[rd_idx];

            case (state)
                S_IDLE: begin
                    if (tick_start) begin
                        syn_q <= syn;
                        idx   <= '0;
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (commit) begin
                        if (in_refrac) begin
                            refrac_mem[idx] <= refrac_mem[idx] - 4'd1;
                            v_mem[idx]      <= 8'd0;
                        end else if (fire) begin
                            refrac_mem[idx] <= REFRAC_INIT;
                            v_mem[idx]      <= 8'd0;
                        end else begin
                            v_mem[idx] <= v_leaked;
                        end
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A newly committed spike replaces a consumed one in the same cycle.
            if (commit && fire) begin
                spike_valid <= 1'b1;
                spike_id    <= idx;
            end else if (spike_ready) begin
                spike_valid <= 1'b0;
            end
        end
    end

endmodule
